// File: rtl/ex_stage_md.sv
// D->E pipeline register with a multi-cycle multiply/divide unit and HI/LO registers.
// Latency: E fields one cycle after D; HI/LO commit MULT_LAT/DIV_LAT edges after the issue edge.
// Backpressure: hold freezes E, flush inserts a bubble; md_busy tells the hazard unit to stall MD ops in D.
module ex_stage_md #(
  parameter int W        = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int TNEW_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [W-1:0]      d_instr,
  input  logic [W-1:0]      d_pc,
  input  logic [W-1:0]      d_rs,
  input  logic [W-1:0]      d_rt,
  input  logic [W-1:0]      d_imm,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [2:0]        d_md_op,
  output logic [W-1:0]      e_instr,
  output logic [W-1:0]      e_pc,
  output logic [W-1:0]      e_rs,
  output logic [W-1:0]      e_rt,
  output logic [W-1:0]      e_imm,
  output logic [TNEW_W-1:0] e_tnew,
  output logic              md_busy,
  output logic [W-1:0]      hi,
  output logic [W-1:0]      lo
);

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_LAT_C = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_LAT_C  = CW'(DIV_LAT);

  // E-stage pipeline state
  logic [W-1:0]      e_instr_q, e_pc_q, e_rs_q, e_rt_q, e_imm_q;
  logic [W-1:0]      e_instr_d, e_pc_d, e_rs_d, e_rt_d, e_imm_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  md_op_e            e_md_op_q, e_md_op_d;
  logic              fresh_q, fresh_d;

  // MD unit state
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      hi_q, lo_q, sh_hi_q, sh_lo_q;
  logic              sh_vld_q;

  // Combinational MD datapath
  logic              issue, is_mult, is_div;
  logic [2*W-1:0]    prod_s, prod_u;
  logic              a_neg, b_neg, div_zero;
  logic [W-1:0]      a_mag, b_mag, b_safe, uq, ur, quot, rem;
  logic [W-1:0]      res_hi, res_lo;

  // Next E contents: flush beats hold beats load; fresh marks a newly loaded instruction
  always_comb begin
    e_instr_d = e_instr_q;
    e_pc_d    = e_pc_q;
    e_rs_d    = e_rs_q;
    e_rt_d    = e_rt_q;
    e_imm_d   = e_imm_q;
    e_tnew_d  = e_tnew_q;
    e_md_op_d = e_md_op_q;
    fresh_d   = 1'b0;
    if (flush) begin
      e_instr_d = '0;
      e_pc_d    = d_pc;
      e_rs_d    = '0;
      e_rt_d    = '0;
      e_imm_d   = '0;
      e_tnew_d  = '0;
      e_md_op_d = MD_NONE;
    end else if (!hold) begin
      e_instr_d = d_instr;
      e_pc_d    = d_pc;
      e_rs_d    = d_rs;
      e_rt_d    = d_rt;
      e_imm_d   = d_imm;
      e_tnew_d  = (d_tnew == '0) ? '0 : d_tnew - TNEW_W'(1);
      e_md_op_d = md_op_e'(d_md_op);
      fresh_d   = 1'b1;
    end
  end

  // E register bank
  always_ff @(posedge clk) begin
    if (reset) begin
      e_instr_q <= '0;
      e_pc_q    <= '0;
      e_rs_q    <= '0;
      e_rt_q    <= '0;
      e_imm_q   <= '0;
      e_tnew_q  <= '0;
      e_md_op_q <= MD_NONE;
      fresh_q   <= 1'b0;
    end else begin
      e_instr_q <= e_instr_d;
      e_pc_q    <= e_pc_d;
      e_rs_q    <= e_rs_d;
      e_rt_q    <= e_rt_d;
      e_imm_q   <= e_imm_d;
      e_tnew_q  <= e_tnew_d;
      e_md_op_q <= e_md_op_d;
      fresh_q   <= fresh_d;
    end
  end

  // Issue decode and result computation; signed divide works on magnitudes then restores signs
  always_comb begin
    is_mult  = (e_md_op_q == MD_MULT) || (e_md_op_q == MD_MULTU);
    is_div   = (e_md_op_q == MD_DIV)  || (e_md_op_q == MD_DIVU);
    issue    = fresh_q && (is_mult || is_div);
    prod_s   = {{W{e_rs_q[W-1]}}, e_rs_q} * {{W{e_rt_q[W-1]}}, e_rt_q};
    prod_u   = {{W{1'b0}}, e_rs_q} * {{W{1'b0}}, e_rt_q};
    a_neg    = (e_md_op_q == MD_DIV) && e_rs_q[W-1];
    b_neg    = (e_md_op_q == MD_DIV) && e_rt_q[W-1];
    a_mag    = a_neg ? -e_rs_q : e_rs_q;
    b_mag    = b_neg ? -e_rt_q : e_rt_q;
    div_zero = (e_rt_q == '0);
    b_safe   = div_zero ? W'(1) : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -uq : uq;
    rem      = a_neg ? -ur : ur;
    res_hi   = rem;
    res_lo   = quot;
    if (e_md_op_q == MD_MULT) begin
      res_hi = prod_s[2*W-1:W];
      res_lo = prod_s[W-1:0];
    end else if (e_md_op_q == MD_MULTU) begin
      res_hi = prod_u[2*W-1:W];
      res_lo = prod_u[W-1:0];
    end
  end

  // MD countdown, shadow capture, HI/LO commit; a pending commit wins over mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sh_hi_q  <= '0;
      sh_lo_q  <= '0;
      sh_vld_q <= 1'b0;
    end else begin
      if (issue) begin
        cnt_q    <= is_mult ? MULT_LAT_C : DIV_LAT_C;
        sh_hi_q  <= res_hi;
        sh_lo_q  <= res_lo;
        sh_vld_q <= is_mult || !div_zero;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (fresh_q && e_md_op_q == MD_MTHI) hi_q <= e_rs_q;
      if (fresh_q && e_md_op_q == MD_MTLO) lo_q <= e_rs_q;
      if (!issue && cnt_q == CW'(1) && sh_vld_q) begin
        hi_q <= sh_hi_q;
        lo_q <= sh_lo_q;
      end
    end
  end

  assign e_instr = e_instr_q;
  assign e_pc    = e_pc_q;
  assign e_rs    = e_rs_q;
  assign e_rt    = e_rt_q;
  assign e_imm   = e_imm_q;
  assign e_tnew  = e_tnew_q;
  assign md_busy = issue || (cnt_q != '0);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: pipeline register behaviour and HI/LO results against a reference model.
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        reset, hold, flush;
  logic [31:0] d_instr, d_pc, d_rs, d_rt, d_imm;
  logic [2:0]  d_tnew, d_md_op;
  logic [31:0] e_instr, e_pc, e_rs, e_rt, e_imm;
  logic [2:0]  e_tnew;
  logic        md_busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_stage_md #(.W(32), .MULT_LAT(5), .DIV_LAT(10), .TNEW_W(3)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .d_instr(d_instr), .d_pc(d_pc), .d_rs(d_rs), .d_rt(d_rt), .d_imm(d_imm),
    .d_tnew(d_tnew), .d_md_op(d_md_op),
    .e_instr(e_instr), .e_pc(e_pc), .e_rs(e_rs), .e_rt(e_rt), .e_imm(e_imm),
    .e_tnew(e_tnew), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural effect of one MD op on HI/LO
  function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    int sa, sb;
    longint p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      3'd2: begin pu = 64'(a) * 64'(b); h = pu[63:32]; l = pu[31:0]; end
      3'd3: begin
        if (sb == 0) return;
        if (sa == 32'sh80000000 && sb == -1) begin l = 32'h80000000; h = 0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      3'd4: begin
        if (b == 0) return;
        l = a / b; h = a % b;
      end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  function automatic int md_lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5 + 1;
    if (op == 3'd3 || op == 3'd4) return 10 + 1;
    return 0;
  endfunction

  task automatic load_d(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic [2:0] tnew,
                        input logic [2:0] op);
    d_instr = instr; d_pc = pc; d_rs = rs; d_rt = rt; d_imm = imm; d_tnew = tnew; d_md_op = op;
    tick();
    d_md_op = 3'd0;
  endtask

  // Loads one MD op and returns the number of cycles md_busy stays high (bounded)
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    load_d(32'h0000_0018, 32'h0000_0400, a, b, 32'h0, 3'd1, op);
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    d_instr = $urandom; d_pc = $urandom; d_rs = $urandom; d_rt = $urandom; d_imm = $urandom;
    d_tnew = 3'd5; d_md_op = 3'd1;
    tick(); tick();
    checks++;
    if ({e_instr, e_pc, e_rs, e_rt, e_imm, e_tnew, md_busy, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_state: got instr=%h pc=%h rs=%h rt=%h imm=%h tnew=%0d busy=%b hi=%h lo=%h, want all 0",
               e_instr, e_pc, e_rs, e_rt, e_imm, e_tnew, md_busy, hi, lo);
    end
    d_instr = 0; d_pc = 0; d_rs = 0; d_rt = 0; d_imm = 0; d_tnew = 0; d_md_op = 0;
    reset = 1'b0;
    tick();
    checks++;
    if ({e_instr, e_pc, e_tnew, md_busy, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_release: got instr=%h pc=%h tnew=%0d busy=%b hi=%h lo=%h, want all 0",
               e_instr, e_pc, e_tnew, md_busy, hi, lo);
    end
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_load();
    logic [31:0] m_instr, m_pc, m_rs, m_rt, m_imm;
    logic [2:0]  m_tnew;
    load_d(32'h012A4020, 32'h0000_1000, 32'h11, 32'h22, 32'h33, 3'd2, 3'd0);
    checks++;
    if (e_instr !== 32'h012A4020 || e_tnew !== 3'd1) begin
      errors++;
      $display("FAIL load_tnew2: got instr=%h tnew=%0d, want 012a4020 tnew=1", e_instr, e_tnew);
    end
    load_d(32'h012A4020, 32'h0000_1004, 32'h11, 32'h22, 32'h33, 3'd0, 3'd0);
    checks++;
    if (e_tnew !== 3'd0 || e_pc !== 32'h0000_1004) begin
      errors++;
      $display("FAIL load_tnew0: got tnew=%0d pc=%h, want tnew=0 pc=00001004", e_tnew, e_pc);
    end
    m_instr = e_instr; m_pc = e_pc; m_rs = 32'h11; m_rt = 32'h22; m_imm = 32'h33; m_tnew = 3'd0;
    for (int i = 0; i < 24; i++) begin
      hold  = ($urandom % 3) == 0;
      flush = ($urandom % 5) == 0;
      d_instr = $urandom; d_pc = $urandom; d_rs = $urandom; d_rt = $urandom; d_imm = $urandom;
      d_tnew = 3'($urandom); d_md_op = 3'd0;
      tick();
      if (flush) begin
        m_instr = 0; m_pc = d_pc; m_rs = 0; m_rt = 0; m_imm = 0; m_tnew = 0;
      end else if (!hold) begin
        m_instr = d_instr; m_pc = d_pc; m_rs = d_rs; m_rt = d_rt; m_imm = d_imm;
        m_tnew = (d_tnew == 0) ? 3'd0 : d_tnew - 3'd1;
      end
      checks++;
      if ({e_instr, e_pc, e_rs, e_rt, e_imm, e_tnew} !== {m_instr, m_pc, m_rs, m_rt, m_imm, m_tnew}) begin
        errors++;
        $display("FAIL pipe_rand[%0d] hold=%b flush=%b: got %h %h %h %h %h %0d, want %h %h %h %h %h %0d",
                 i, hold, flush, e_instr, e_pc, e_rs, e_rt, e_imm, e_tnew,
                 m_instr, m_pc, m_rs, m_rt, m_imm, m_tnew);
      end
    end
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    run_md(3'd1, 32'hFFFFFFFF, 32'd5, n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL mult_busy_cycles: got %0d, want 6", n);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL mult_result: got hi=%h lo=%h, want ffffffff fffffffb", hi, lo);
    end
    run_md(3'd2, 32'hFFFFFFFF, 32'd5, n);
    checks++;
    if (hi !== 32'h00000004 || lo !== 32'hFFFFFFFB || n !== 6) begin
      errors++;
      $display("FAIL multu_result: got hi=%h lo=%h busy=%0d, want 00000004 fffffffb busy=6", hi, lo, n);
    end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_div();
    int n;
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, n);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || n !== 11) begin
      errors++;
      $display("FAIL div_neg7_by2: got hi=%h lo=%h busy=%0d, want ffffffff fffffffd busy=11", hi, lo, n);
    end
    run_md(3'd3, 32'h12345678, 32'd0, n);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || n !== 11) begin
      errors++;
      $display("FAIL div_by_zero: got hi=%h lo=%h busy=%0d, want unchanged ffffffff fffffffd busy=11", hi, lo, n);
    end
    run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_intmin_by_m1: got hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    run_md(3'd4, 32'hFFFFFFF9, 32'd2, n);
    checks++;
    if (hi !== 32'h1 || lo !== 32'h7FFFFFFC) begin
      errors++;
      $display("FAIL divu: got hi=%h lo=%h, want 00000001 7ffffffc", hi, lo);
    end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_hold_flush();
    int n, commits;
    logic [63:0] prev;
    load_d(32'h0, 32'h0, 32'h11111111, 32'h0, 32'h0, 3'd0, 3'd5);
    load_d(32'h0, 32'h0, 32'h22222222, 32'h0, 32'h0, 3'd0, 3'd6);
    tick();
    load_d(32'hABCD0018, 32'h0000_2000, 32'd3, 32'd7, 32'h0, 3'd2, 3'd1);
    prev = {hi, lo};
    commits = 0;
    for (int i = 0; i < 12; i++) begin
      hold = (i < 3);
      tick();
      if (i < 3) begin
        checks++;
        if (e_instr !== 32'hABCD0018 || e_rs !== 32'd3 || e_rt !== 32'd7 || e_tnew !== 3'd1) begin
          errors++;
          $display("FAIL hold_stable[%0d]: got instr=%h rs=%h rt=%h tnew=%0d, want abcd0018 3 7 1",
                   i, e_instr, e_rs, e_rt, e_tnew);
        end
      end
      if ({hi, lo} !== prev) commits++;
      prev = {hi, lo};
    end
    hold = 1'b0;
    checks++;
    if (commits !== 1 || hi !== 32'h0 || lo !== 32'd21) begin
      errors++;
      $display("FAIL hold_one_commit: got commits=%0d hi=%h lo=%h, want 1 00000000 00000015", commits, hi, lo);
    end
    load_d(32'hABCD0018, 32'h0000_3000, 32'd6, 32'hFFFFFFFE, 32'h0, 3'd2, 3'd1);
    tick(); tick();
    flush = 1'b1; d_pc = 32'h0000_3008;
    tick();
    flush = 1'b0; d_instr = 32'h0;
    checks++;
    if (e_instr !== 32'h0 || e_pc !== 32'h0000_3008 || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_bubble: got instr=%h pc=%h busy=%b, want 00000000 00003008 busy=1", e_instr, e_pc, md_busy);
    end
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4 || n !== 3) begin
      errors++;
      $display("FAIL flush_commit: got hi=%h lo=%h remaining=%0d, want ffffffff fffffff4 remaining=3", hi, lo, n);
    end
  endtask

  task automatic test_reset_mid();
    load_d(32'h18, 32'h0, 32'd9, 32'd9, 32'h0, 3'd0, 3'd1);
    tick(); tick(); tick(); tick();
    checks++;
    if (md_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b, want 1", md_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: got hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, md_busy);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_no_commit: got hi=%h lo=%h, want 0 0", hi, lo);
    end
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_mthi();
    load_d(32'h0, 32'h0, 32'h5A5A, 32'h0, 32'h0, 3'd0, 3'd6);
    load_d(32'h0, 32'h0, 32'h1234, 32'h0, 32'h0, 3'd0, 3'd5);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h5A5A) begin
      errors++;
      $display("FAIL mthi_before: got hi=%h lo=%h, want 00000000 00005a5a", hi, lo);
    end
    tick();
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5A5A) begin
      errors++;
      $display("FAIL mthi_after: got hi=%h lo=%h, want 00001234 00005a5a", hi, lo);
    end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_random();
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = ($urandom % 6 == 0) ? 32'h80000000 : $urandom;
      case ($urandom % 4)
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      md_ref(op, a, b, exp_hi, exp_lo);
      run_md(op, a, b, n);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || n !== md_lat(op)) begin
        errors++;
        $display("FAIL md_rand[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h busy=%0d, want hi=%h lo=%h busy=%0d",
                 i, op, a, b, hi, lo, n, exp_hi, exp_lo, md_lat(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_mult();
    test_div();
    test_hold_flush();
    test_reset_mid();
    test_mthi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
